mem_write_monitor: RTL and testbench

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

---
 rtl/mem_write_monitor.sv | 152 +++++++++++++++
 tb/tb_mem_write_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// Data-memory write monitor: classifies each store into DATA/IMG/OTHER,
// counts events per region and queues records for a valid/ready consumer.
// Ports:
//   CLK, RST          clock, async active-low reset
//   enable_i, clear_i capture enable, synchronous clear
//   wr_en_i, wr_addr_i, wr_data_i, pc_i  observed store
//   rec_ready_i / rec_valid_o, rec_*     head-of-queue record handshake
//   *_cnt_o, overflow_o, cycle_o         statistics
module mem_write_monitor #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int IMG_BASE   = 262144,
  parameter int DATA_LIMIT = 4095,
  parameter int CAP_OTHER  = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [31:0]       pc_i,
  input  logic              rec_ready_i,
  output logic              rec_valid_o,
  output logic [1:0]        rec_region_o,
  output logic [ADDR_W-1:0] rec_offset_o,
  output logic [DATA_W-1:0] rec_data_o,
  output logic [31:0]       rec_pc_o,
  output logic [31:0]       rec_ts_o,
  output logic [31:0]       data_cnt_o,
  output logic [31:0]       img_cnt_o,
  output logic [31:0]       other_cnt_o,
  output logic [31:0]       drop_cnt_o,
  output logic              overflow_o,
  output logic [31:0]       cycle_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] R_DATA  = 2'd0;
  localparam logic [1:0] R_IMG   = 2'd1;
  localparam logic [1:0] R_OTHER = 2'd2;
  localparam logic [ADDR_W-1:0] IMG_A  = ADDR_W'(IMG_BASE);
  localparam logic [ADDR_W-1:0] DATA_A = ADDR_W'(DATA_LIMIT);

  typedef struct packed {
    logic [1:0]        region;
    logic [ADDR_W-1:0] offset;
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic [31:0]       ts;
  } rec_t;

  rec_t              mem [DEPTH];
  rec_t              head;
  rec_t              new_rec;
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              cap;
  logic              queueable;
  logic              pop;
  logic              push;
  logic              drop;
  logic [1:0]        region;
  logic [ADDR_W-1:0] offset;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // IMG wins when the two windows overlap.
  always_comb begin
    region = R_OTHER;
    offset = wr_addr_i;
    if (wr_addr_i >= IMG_A) begin
      region = R_IMG;
      offset = wr_addr_i - IMG_A;
    end else if (wr_addr_i <= DATA_A) begin
      region = R_DATA;
    end
  end

  // Pointers carry one extra bit so full and empty are distinct.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign cap       = wr_en_i & enable_i & ~clear_i;
  assign queueable = (region != R_OTHER) || (CAP_OTHER != 0);
  assign pop       = ~empty & rec_ready_i & ~clear_i;
  assign push      = cap & queueable & (~full | pop);
  assign drop      = cap & queueable & full & ~pop;

  assign new_rec = '{region: region, offset: offset,
                     data: wr_data_i, pc: pc_i, ts: cycle_o};

  // Storage needs no reset: only entries between the pointers are visible.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[PW-1:0]] <= new_rec;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_cnt_o  <= '0;
      img_cnt_o   <= '0;
      other_cnt_o <= '0;
      drop_cnt_o  <= '0;
      overflow_o  <= 1'b0;
      cycle_o     <= '0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_cnt_o  <= '0;
      img_cnt_o   <= '0;
      other_cnt_o <= '0;
      drop_cnt_o  <= '0;
      overflow_o  <= 1'b0;
      cycle_o     <= '0;
    end else begin
      cycle_o <= cycle_o + 32'd1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (cap) begin
        if (region == R_IMG)
          img_cnt_o <= sat_inc(img_cnt_o);
        else if (region == R_DATA)
          data_cnt_o <= sat_inc(data_cnt_o);
        else
          other_cnt_o <= sat_inc(other_cnt_o);
      end
      if (drop) begin
        drop_cnt_o <= sat_inc(drop_cnt_o);
        overflow_o <= 1'b1;
      end
    end
  end

  // Record fields read as zero whenever nothing is queued.
  assign head         = mem[rd_ptr[PW-1:0]];
  assign rec_valid_o  = ~empty;
  assign rec_region_o = empty ? '0 : head.region;
  assign rec_offset_o = empty ? '0 : head.offset;
  assign rec_data_o   = empty ? '0 : head.data;
  assign rec_pc_o     = empty ? '0 : head.pc;
  assign rec_ts_o     = empty ? '0 : head.ts;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_mem_write_monitor;

  localparam int DEPTH = 4;
  localparam int IMG   = 262144;
  localparam int DL    = 4095;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enable_i, clear_i, wr_en_i, rec_ready_i;
  logic [31:0] wr_addr_i, wr_data_i, pc_i;
  logic        rec_valid_o, overflow_o;
  logic [1:0]  rec_region_o;
  logic [31:0] rec_offset_o, rec_data_o, rec_pc_o, rec_ts_o;
  logic [31:0] data_cnt_o, img_cnt_o, other_cnt_o, drop_cnt_o, cycle_o;

  mem_write_monitor #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .IMG_BASE(IMG), .DATA_LIMIT(DL), .CAP_OTHER(0)
  ) dut (
    .CLK(CLK), .RST(RST),
    .enable_i(enable_i), .clear_i(clear_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .pc_i(pc_i),
    .rec_ready_i(rec_ready_i), .rec_valid_o(rec_valid_o),
    .rec_region_o(rec_region_o), .rec_offset_o(rec_offset_o),
    .rec_data_o(rec_data_o), .rec_pc_o(rec_pc_o),
    .rec_ts_o(rec_ts_o),
    .data_cnt_o(data_cnt_o), .img_cnt_o(img_cnt_o),
    .other_cnt_o(other_cnt_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o), .cycle_o(cycle_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  region;
    logic [31:0] off, data, pc, ts;
  } mrec_t;

  mrec_t       q[$];
  logic [31:0] m_cyc, m_dat, m_img, m_oth, m_drop;
  bit          m_ovf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_dat = 0; m_img = 0; m_oth = 0; m_drop = 0;
    m_ovf = 0;
  endtask

  // Applies the inputs present at the edge just taken.
  task automatic model_step();
    mrec_t r;
    if (clear_i) begin
      model_reset();
      return;
    end
    if (q.size() > 0 && rec_ready_i) void'(q.pop_front());
    if (wr_en_i && enable_i) begin
      r.data = wr_data_i;
      r.pc   = pc_i;
      r.ts   = m_cyc;
      r.off  = wr_addr_i;
      if (wr_addr_i >= IMG) begin
        r.region = 1; r.off = wr_addr_i - IMG; m_img = sat(m_img);
      end else if (wr_addr_i <= DL) begin
        r.region = 0; m_dat = sat(m_dat);
      end else begin
        r.region = 2; m_oth = sat(m_oth);
      end
      if (r.region != 2) begin
        if (q.size() < DEPTH) q.push_back(r);
        else begin
          m_drop = sat(m_drop);
          m_ovf  = 1;
        end
      end
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic compare_all();
    check("valid", rec_valid_o, q.size() > 0);
    if (q.size() > 0) begin
      check("region", rec_region_o, q[0].region);
      check("offset", rec_offset_o, q[0].off);
      check("data", rec_data_o, q[0].data);
      check("pc", rec_pc_o, q[0].pc);
      check("ts", rec_ts_o, q[0].ts);
    end
    check("data_cnt", data_cnt_o, m_dat);
    check("img_cnt", img_cnt_o, m_img);
    check("other_cnt", other_cnt_o, m_oth);
    check("drop_cnt", drop_cnt_o, m_drop);
    check("overflow", overflow_o, m_ovf);
    check("cycle", cycle_o, m_cyc);
  endtask

  // Called at a falling edge: drive, take one rising edge, compare.
  task automatic tick(input bit e, input bit c, input bit w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] p, input bit r);
    enable_i = e; clear_i = c; wr_en_i = w;
    wr_addr_i = a; wr_data_i = d; pc_i = p; rec_ready_i = r;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, DL);
      1:       return IMG + $urandom_range(0, 1000);
      default: return $urandom_range(DL + 1, IMG - 1);
    endcase
  endfunction

  task automatic check_zero_state(input string tag);
    check({tag, "_valid"}, rec_valid_o, 0);
    check({tag, "_data"}, rec_data_o, 0);
    check({tag, "_offset"}, rec_offset_o, 0);
    check({tag, "_ts"}, rec_ts_o, 0);
    check({tag, "_dcnt"}, data_cnt_o, 0);
    check({tag, "_icnt"}, img_cnt_o, 0);
    check({tag, "_drop"}, drop_cnt_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_cycle"}, cycle_o, 0);
  endtask

  int nvalid;

  initial begin
    RST = 1'b0;
    enable_i = 0; clear_i = 0; wr_en_i = 0; rec_ready_i = 0;
    wr_addr_i = 0; wr_data_i = 0; pc_i = 0;
    model_reset();
    #3;
    check_zero_state("reset");
    @(negedge CLK);
    RST = 1'b1;

    // IMG capture stamped at cycle 5
    repeat (5) tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 1, 262150, 77, 40, 1);
    check("img_valid", rec_valid_o, 1);
    check("img_region", rec_region_o, 1);
    check("img_offset", rec_offset_o, 6);
    check("img_data", rec_data_o, 77);
    check("img_pc", rec_pc_o, 40);
    check("img_ts", rec_ts_o, 5);
    check("img_cnt1", img_cnt_o, 1);
    tick(1, 0, 0, 0, 0, 0, 1);

    // DATA queued, OTHER counted only
    tick(1, 0, 1, 100, 11, 4, 0);
    tick(1, 0, 1, 8000, 12, 8, 0);
    check("d_cnt1", data_cnt_o, 1);
    check("o_cnt1", other_cnt_o, 1);
    check("d_off100", rec_offset_o, 100);
    tick(1, 0, 0, 0, 0, 0, 1);
    check("one_rec", rec_valid_o, 0);

    // overflow then ordered drain
    tick(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) tick(1, 0, 1, i, i, i, 0);
    check("ovf_drop", drop_cnt_o, 3);
    check("ovf_flag", overflow_o, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_off", rec_offset_o, i);
      tick(1, 0, 0, 0, 0, 0, 1);
    end
    check("drained", rec_valid_o, 0);

    // full with simultaneous push and pop
    tick(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 1, i, i, i, 0);
    tick(1, 0, 1, 50, 50, 50, 1);
    check("fp_drop", drop_cnt_o, 0);
    nvalid = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (rec_valid_o) nvalid++;
      tick(1, 0, 0, 0, 0, 0, 1);
    end
    check("fp_occ", nvalid, DEPTH);

    // clear beats a coincident write
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 200 + i, i, i, 0);
    tick(1, 1, 1, 300, 1, 1, 1);
    check("clr_valid", rec_valid_o, 0);
    check("clr_dcnt", data_cnt_o, 0);
    check("clr_cycle", cycle_o, 0);

    // async reset with records queued
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 400 + i, i, i, 0);
    #2 RST = 1'b0;
    #1 check_zero_state("async");
    model_reset();
    #1 RST = 1'b1;
    repeat (3) tick(1, 0, 0, 0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      tick($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 6, rand_addr(), $urandom(),
           $urandom(), $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
